// File: rtl/counter_pkg.sv
// Shared definitions for the pipelined counter family (up and down variants).
// Holds default geometry, the pipeline latency helper and the next-count operation encoding.
package counter_pkg;

    localparam int unsigned CNT_DEF_N       = 32'd4;
    localparam int unsigned CNT_DEF_STAGES  = 32'd2;
    localparam int unsigned CNT_DEF_LATENCY = CNT_DEF_STAGES + 32'd1;

    typedef enum logic [1:0] {
        CNT_OP_HOLD = 2'd0,
        CNT_OP_INC  = 2'd1,
        CNT_OP_WRAP = 2'd2,
        CNT_OP_LOAD = 2'd3
    } cnt_op_e;

    // Output latency: the delay stages plus the output register.
    function automatic int unsigned cnt_latency(input int unsigned stages);
        return stages + 32'd1;
    endfunction

    // Load beats enable; enable at the terminal count wraps instead of incrementing.
    function automatic cnt_op_e cnt_select_op(input logic load, input logic en, input logic at_max);
        cnt_op_e op;
        if (load) begin
            op = CNT_OP_LOAD;
        end else if (en && at_max) begin
            op = CNT_OP_WRAP;
        end else if (en) begin
            op = CNT_OP_INC;
        end else begin
            op = CNT_OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_pipe_stage.sv
// One delay-line register of the counter pipeline, cleared asynchronously by reset_n.
module counter_pipe_stage
    import counter_pkg::*;
#(
    parameter int unsigned W = CNT_DEF_N + 32'd1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_r;

    // Unconditional capture every clock; only reset stops the flow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= {W{1'b0}};
        end else begin
            data_r <= d;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/pipelined_up_counter.sv
// Up counter with load, terminal count and a fixed-latency output pipeline.
// q/tc lag the internal count by STAGES+1 edges; q_valid marks when the pipe holds real data.
module pipelined_up_counter
    import counter_pkg::*;
#(
    parameter int unsigned N      = CNT_DEF_N,
    parameter int unsigned STAGES = CNT_DEF_STAGES,
    parameter int unsigned MAX    = (32'd1 << N) - 32'd1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         q_valid
);

    localparam int unsigned     LAT       = cnt_latency(STAGES);
    localparam logic [N-1:0]    MAX_V     = N'(MAX);
    localparam logic [N-1:0]    CNT_ZERO  = {N{1'b0}};
    localparam logic [N-1:0]    CNT_ONE   = N'(1'b1);
    localparam longint unsigned MAX_LIMIT = (64'd1 << N) - 64'd1;

    if (N < 32'd1) begin : g_bad_width
        $error("pipelined_up_counter: N must be at least 1");
    end
    if (STAGES < 32'd1) begin : g_bad_stages
        $error("pipelined_up_counter: STAGES must be at least 1");
    end
    if ((MAX < 32'd1) || (64'(MAX) > MAX_LIMIT)) begin : g_bad_max
        $error("pipelined_up_counter: MAX must lie in 1 .. 2**N-1");
    end

    cnt_op_e      op_s;
    logic         at_max_s;
    logic [N-1:0] load_sat_s;
    logic [N-1:0] cnt_next_s;
    logic [N-1:0] cnt_r;
    logic [N:0]   out_r;
    logic [LAT-1:0] vld_r;
    logic [N:0]   chain_s [0:STAGES];

    assign at_max_s = (cnt_r == MAX_V);

    // Next-count selection; loads above MAX saturate to MAX.
    always_comb begin
        op_s       = cnt_select_op(load, en, at_max_s);
        load_sat_s = load_val;
        cnt_next_s = cnt_r;
        if (load_val > MAX_V) begin
            load_sat_s = MAX_V;
        end else begin
            load_sat_s = load_val;
        end
        case (op_s)
            CNT_OP_LOAD: cnt_next_s = load_sat_s;
            CNT_OP_WRAP: cnt_next_s = CNT_ZERO;
            CNT_OP_INC:  cnt_next_s = cnt_r + CNT_ONE;
            CNT_OP_HOLD: cnt_next_s = cnt_r;
            default:     cnt_next_s = cnt_r;
        endcase
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // The terminal-count flag travels with its count so the two stay aligned at the output.
    assign chain_s[0] = {at_max_s, cnt_r};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        counter_pipe_stage #(
            .W(N + 32'd1)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (chain_s[i]),
            .q       (chain_s[i+1])
        );
    end

    // Output register plus the validity shifter that fills with ones after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r <= {(N + 1){1'b0}};
            vld_r <= {LAT{1'b0}};
        end else begin
            out_r <= chain_s[STAGES];
            vld_r <= {vld_r[LAT-2:0], 1'b1};
        end
    end

    assign q       = out_r[N-1:0];
    assign tc      = out_r[N];
    assign q_valid = vld_r[LAT-1];

endmodule

// File: tb/tb_pipelined_up_counter.sv
// Scoreboard bench: two counters (MAX=15 and MAX=9) share random and directed stimulus.
module tb_pipelined_up_counter;

    localparam int N      = 4;
    localparam int STAGES = 2;
    localparam int LAT    = STAGES + 1;
    localparam int MAX_A  = 15;
    localparam int MAX_B  = 9;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       en       = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, qv_a, qv_b;

    int n_checks = 0;
    int n_fail   = 0;
    int model_a  = 0;
    int model_b  = 0;
    logic [4:0] sb_a [$];
    logic [4:0] sb_b [$];

    always #5 clk = ~clk;

    pipelined_up_counter #(.N(N), .STAGES(STAGES)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
        .q(q_a), .tc(tc_a), .q_valid(qv_a)
    );

    pipelined_up_counter #(.N(N), .STAGES(STAGES), .MAX(MAX_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
        .q(q_b), .tc(tc_b), .q_valid(qv_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int next_cnt(input int cur, input bit ld, input bit e, input int lv, input int mx);
        if (ld) return (lv > mx) ? mx : lv;
        if (e) return (cur + 1) % (mx + 1);
        return cur;
    endfunction

    function automatic logic [4:0] mk_item(input int v, input int mx);
        logic [3:0] val;
        val = v[3:0];
        return {(v == mx), val};
    endfunction

    // Drive one cycle of inputs; at the edge record what the count was and advance the models.
    task automatic cycle(input bit e, input bit ld, input int lv);
        en       = e;
        load     = ld;
        load_val = lv[3:0];
        @(posedge clk);
        sb_a.push_back(mk_item(model_a, MAX_A));
        sb_b.push_back(mk_item(model_b, MAX_B));
        model_a = next_cnt(model_a, ld, e, lv, MAX_A);
        model_b = next_cnt(model_b, ld, e, lv, MAX_B);
        #1;
    endtask

    // Assert reset between edges, check the immediate clear, then release away from the edge.
    task automatic do_reset(input int hold_cycles);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'({qv_a, tc_a, q_a, qv_b, tc_b, q_b}), 32'd0);
        sb_a.delete();
        sb_b.delete();
        model_a = 0;
        model_b = 0;
        en      = 1'b0;
        load    = 1'b0;
        repeat (hold_cycles) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: valid outputs must match the scoreboard head with exactly LAT entries in flight.
    always @(negedge clk) begin
        logic [4:0] exp;
        if (qv_a) begin
            check("latency_a", 32'(sb_a.size()), 32'(LAT));
            if (sb_a.size() > 0) begin
                exp = sb_a.pop_front();
                check("q_tc_a", 32'({tc_a, q_a}), 32'(exp));
            end
        end else begin
            check("idle_out_a", 32'({tc_a, q_a}), 32'd0);
            check("early_valid_a", 32'(sb_a.size() < LAT), 32'd1);
        end
        if (qv_b) begin
            check("latency_b", 32'(sb_b.size()), 32'(LAT));
            if (sb_b.size() > 0) begin
                exp = sb_b.pop_front();
                check("q_tc_b", 32'({tc_b, q_b}), 32'(exp));
            end
        end else begin
            check("idle_out_b", 32'({tc_b, q_b}), 32'd0);
            check("early_valid_b", 32'(sb_b.size() < LAT), 32'd1);
        end
    end

    initial begin
        #1;
        check("reset_state", 32'({qv_a, tc_a, q_a, qv_b, tc_b, q_b}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Free-running count through the wrap of both counters.
        repeat (20) cycle(1'b1, 1'b0, 0);

        // Load beats enable, then counting resumes; a load with enable low then holds.
        cycle(1'b1, 1'b1, 9);
        repeat (2) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 9);
        repeat (5) cycle(1'b0, 1'b0, 0);

        // Load above MAX saturates on the MAX=9 counter.
        cycle(1'b0, 1'b1, 12);
        repeat (12) cycle(1'b1, 1'b0, 0);

        // Reset in the middle of counting, with q showing 6.
        do_reset(1);
        repeat (9) cycle(1'b1, 1'b0, 0);
        check("q_before_reset", 32'(q_a), 32'd6);
        do_reset(2);
        repeat (10) cycle(1'b1, 1'b0, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                      int'($urandom_range(0, 15)));
            end
        end

        repeat (4) cycle(1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
